// File: rtl/ucc_shadow_stack_pkg.sv
// Shared encodings for the UCC return-integrity logic: ucc_state values, violation codes
// and the monitor FSM states.
package ucc_shadow_stack_pkg;

   typedef enum logic [1:0] {
      UccNot = 2'b00,
      UccIn  = 2'b01,
      UccIrq = 2'b10,
      UccRst = 2'b11
   } ucc_state_e;

   typedef enum logic [1:0] {
      ViolNone      = 2'b00,
      ViolMismatch  = 2'b01,
      ViolUnderflow = 2'b10,
      ViolOverflow  = 2'b11
   } viol_e;

   typedef enum logic {
      StArmed = 1'b0,
      StFault = 1'b1
   } fsm_state_e;

endpackage

// File: rtl/ucc_shadow_stack_ras_mem.sv
// DEPTH x AW return-address register stack: push, pop, top replace and clear, with a
// wrapping pointer and a saturating entry count. Top is read combinationally.
module ucc_shadow_stack_ras_mem #(
   parameter int unsigned AW    = 16,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     system_reset,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     replace,
   input  logic [AW-1:0]            wdata,
   output logic [AW-1:0]            top,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

   logic [AW-1:0] entries [DEPTH];
   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_top;

   assign ptr_top = ptr - PW'(1);
   assign top     = (count == '0) ? '0 : entries[ptr_top];

   // Pushing when full overwrites the slot at ptr, which is the oldest entry.
   always_ff @(posedge clk) begin
      if (system_reset || clear) begin
         ptr   <= '0;
         count <= '0;
      end else if (push) begin
         ptr <= ptr + PW'(1);
         if (count != FullCnt) begin
            count <= count + CW'(1);
         end
      end else if (pop) begin
         ptr   <= ptr_top;
         count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!system_reset && !clear) begin
         if (push) begin
            entries[ptr] <= wdata;
         end else if (replace) begin
            entries[ptr_top] <= wdata;
         end
      end
   end

endmodule

// File: rtl/ucc_shadow_stack.sv
// Return-integrity monitor: checks every UCC exit against an N-deep shadow return stack and
// raises a registered reset request on mismatch, underflow or overflow.
module ucc_shadow_stack
   import ucc_shadow_stack_pkg::*;
#(
   parameter int unsigned    AW            = 16,
   parameter int unsigned    DEPTH         = 8,
   parameter bit             OVF_RESET     = 1'b1,
   parameter logic [AW-1:0]  RESET_HANDLER = '0
) (
   input  logic                     clk,
   input  logic                     system_reset,
   input  logic [AW-1:0]            pc,
   input  logic [1:0]               ucc_state,
   input  logic                     enter_ucc,
   input  logic                     exit_ucc,
   input  logic [AW-1:0]            op_dest,
   output logic                     reset,
   output logic [1:0]               viol_code,
   output logic [$clog2(DEPTH):0]   depth_cnt,
   output logic [AW-1:0]            top_addr
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

   fsm_state_e state_q;
   viol_e      viol_d;
   logic       rst_fault;
   logic       stk_clear, stk_push, stk_pop, stk_replace;
   logic       is_empty, is_full, exit_ok;

   assign is_empty = (depth_cnt == '0);
   assign is_full  = (depth_cnt == FullCnt);
   assign exit_ok  = exit_ucc && !is_empty && (pc == top_addr);

   always_comb begin
      viol_d      = ViolNone;
      rst_fault   = 1'b0;
      stk_clear   = 1'b0;
      stk_push    = 1'b0;
      stk_pop     = 1'b0;
      stk_replace = 1'b0;
      if (state_q == StFault) begin
         stk_clear = 1'b1;
      end else begin
         unique case (ucc_state)
            UccNot, UccIn: begin
               // A valid exit frees a slot, so enter+exit at full is never an overflow.
               if (exit_ucc && is_empty) begin
                  viol_d = ViolUnderflow;
               end else if (exit_ucc && !exit_ok) begin
                  viol_d = ViolMismatch;
               end else if (OVF_RESET && enter_ucc && is_full && !exit_ok) begin
                  viol_d = ViolOverflow;
               end
               if (viol_d != ViolNone) begin
                  stk_clear = 1'b1;
               end else if (exit_ok && enter_ucc) begin
                  stk_replace = 1'b1;
               end else if (exit_ok) begin
                  stk_pop = 1'b1;
               end else if (enter_ucc) begin
                  stk_push = 1'b1;
               end
            end
            UccIrq: ;
            UccRst: begin
               stk_clear = 1'b1;
               rst_fault = (pc != RESET_HANDLER);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (system_reset) begin
         state_q   <= StFault;
         reset     <= 1'b1;
         viol_code <= ViolNone;
      end else begin
         unique case (state_q)
            StFault: begin
               if (ucc_state == UccRst && pc == RESET_HANDLER) begin
                  state_q   <= StArmed;
                  reset     <= 1'b0;
                  viol_code <= ViolNone;
               end
            end
            StArmed: begin
               if (viol_d != ViolNone) begin
                  state_q   <= StFault;
                  reset     <= 1'b1;
                  viol_code <= viol_d;
               end else if (rst_fault) begin
                  state_q <= StFault;
                  reset   <= 1'b1;
               end
            end
            default: begin
               state_q <= StFault;
               reset   <= 1'b1;
            end
         endcase
      end
   end

   ucc_shadow_stack_ras_mem #(
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_ras_mem (
      .clk          (clk),
      .system_reset (system_reset),
      .clear        (stk_clear),
      .push         (stk_push),
      .pop          (stk_pop),
      .replace      (stk_replace),
      .wdata        (op_dest),
      .top          (top_addr),
      .count        (depth_cnt)
   );

endmodule

// File: tb/tb_ucc_shadow_stack.sv
// Directed bench for ucc_shadow_stack: three instances (DEPTH 8, DEPTH 4 overflow-reset,
// DEPTH 4 circular) share stimulus; expectations are queued per step and checked after the edge.
module tb_ucc_shadow_stack;

   localparam logic [1:0] SNot = 2'b00;
   localparam logic [1:0] SIn  = 2'b01;
   localparam logic [1:0] SIrq = 2'b10;
   localparam logic [1:0] SRst = 2'b11;

   logic        clk = 1'b0;
   logic        system_reset;
   logic [15:0] pc, op_dest;
   logic [1:0]  ucc_state;
   logic        enter_ucc, exit_ucc;

   logic        rst8, rst4o, rst4c;
   logic [1:0]  v8, v4o, v4c;
   logic [3:0]  d8;
   logic [2:0]  d4o, d4c;
   logic [15:0] t8, t4o, t4c;

   always #5 clk = ~clk;

   ucc_shadow_stack #(.AW(16), .DEPTH(8), .OVF_RESET(1'b1), .RESET_HANDLER(16'h0000)) dut8 (
      .clk(clk), .system_reset(system_reset), .pc(pc), .ucc_state(ucc_state),
      .enter_ucc(enter_ucc), .exit_ucc(exit_ucc), .op_dest(op_dest),
      .reset(rst8), .viol_code(v8), .depth_cnt(d8), .top_addr(t8)
   );

   ucc_shadow_stack #(.AW(16), .DEPTH(4), .OVF_RESET(1'b1), .RESET_HANDLER(16'h0000)) dut4o (
      .clk(clk), .system_reset(system_reset), .pc(pc), .ucc_state(ucc_state),
      .enter_ucc(enter_ucc), .exit_ucc(exit_ucc), .op_dest(op_dest),
      .reset(rst4o), .viol_code(v4o), .depth_cnt(d4o), .top_addr(t4o)
   );

   ucc_shadow_stack #(.AW(16), .DEPTH(4), .OVF_RESET(1'b0), .RESET_HANDLER(16'h0000)) dut4c (
      .clk(clk), .system_reset(system_reset), .pc(pc), .ucc_state(ucc_state),
      .enter_ucc(enter_ucc), .exit_ucc(exit_ucc), .op_dest(op_dest),
      .reset(rst4c), .viol_code(v4c), .depth_cnt(d4c), .top_addr(t4c)
   );

   typedef struct {
      string       tag;
      int          inst;
      logic        rst;
      logic [1:0]  viol;
      logic [3:0]  depth;
      logic [15:0] top;
   } exp_t;

   exp_t sbq[$];
   int   ntests = 0;
   int   nfail  = 0;

   task automatic check1(input string tag, input string what, input logic [15:0] obs,
                         input logic [15:0] req);
      ntests++;
      assert (obs === req) else begin
         nfail++;
         $error("FAIL %s %s: got %h expected %h", tag, what, obs, req);
      end
   endtask

   task automatic drive(input logic sr, input logic [1:0] st, input logic [15:0] p,
                        input logic en, input logic ex, input logic [15:0] od);
      system_reset = sr;
      ucc_state    = st;
      pc           = p;
      enter_ucc    = en;
      exit_ucc     = ex;
      op_dest      = od;
   endtask

   task automatic want(input int inst, input string tag, input logic r, input logic [1:0] v,
                       input logic [3:0] d, input logic [15:0] t);
      exp_t e;
      e.tag = tag; e.inst = inst; e.rst = r; e.viol = v; e.depth = d; e.top = t;
      sbq.push_back(e);
   endtask

   task automatic want_all(input string tag, input logic r, input logic [1:0] v,
                           input logic [3:0] d, input logic [15:0] t);
      for (int i = 0; i < 3; i++) want(i, tag, r, v, d, t);
   endtask

   // Outputs of the edge just passed are compared at the following negedge.
   task automatic step;
      exp_t        e;
      logic        r;
      logic [1:0]  v;
      logic [3:0]  d;
      logic [15:0] t;
      string       tg;
      @(negedge clk);
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         case (e.inst)
            0:       begin r = rst8;  v = v8;  d = d8;          t = t8;  end
            1:       begin r = rst4o; v = v4o; d = {1'b0, d4o}; t = t4o; end
            default: begin r = rst4c; v = v4c; d = {1'b0, d4c}; t = t4c; end
         endcase
         tg = $sformatf("%s/i%0d", e.tag, e.inst);
         check1(tg, "reset", {15'd0, r}, {15'd0, e.rst});
         check1(tg, "viol_code", {14'd0, v}, {14'd0, e.viol});
         check1(tg, "depth_cnt", {12'd0, d}, {12'd0, e.depth});
         check1(tg, "top_addr", t, e.top);
      end
   endtask

   initial begin
      // Power-up
      drive(1, SNot, 16'h0000, 0, 0, 16'h0000); want_all("por", 1, 2'b00, 0, 16'h0);    step;
      drive(0, SNot, 16'h0055, 0, 0, 16'h0000); want_all("pre_arm", 1, 2'b00, 0, 16'h0); step;
      drive(0, SRst, 16'h0000, 0, 0, 16'h0000); want_all("arm", 0, 2'b00, 0, 16'h0);     step;

      // Nested calls and matching returns
      drive(0, SIn, 16'h0100, 1, 0, 16'h1000); want_all("n_push1", 0, 0, 1, 16'h1000); step;
      drive(0, SIn, 16'h0104, 1, 0, 16'h2000); want_all("n_push2", 0, 0, 2, 16'h2000); step;
      drive(0, SIn, 16'h0108, 1, 0, 16'h3000); want_all("n_push3", 0, 0, 3, 16'h3000); step;
      drive(0, SIn, 16'h3000, 0, 1, 16'h0000); want_all("n_pop3", 0, 0, 2, 16'h2000);  step;
      drive(0, SNot, 16'h2000, 0, 1, 16'h0000); want_all("n_pop2", 0, 0, 1, 16'h1000); step;
      drive(0, SIn, 16'h1000, 0, 1, 16'h0000); want_all("n_pop1", 0, 0, 0, 16'h0000);  step;

      // Mismatch, held until RST at the handler
      drive(0, SIn, 16'h0200, 1, 0, 16'h1234); want_all("m_push", 0, 0, 1, 16'h1234);  step;
      drive(0, SIn, 16'h1236, 0, 1, 16'h0000); want_all("m_viol", 1, 2'b01, 0, 16'h0); step;
      drive(0, SIn, 16'h1234, 1, 1, 16'h7000); want_all("m_hold", 1, 2'b01, 0, 16'h0); step;
      drive(0, SRst, 16'h0010, 0, 0, 16'h0000); want_all("m_badrst", 1, 2'b01, 0, 16'h0); step;
      drive(0, SRst, 16'h0000, 0, 0, 16'h0000); want_all("m_rearm", 0, 2'b00, 0, 16'h0); step;

      // Underflow
      drive(0, SNot, 16'h0100, 0, 1, 16'h0000); want_all("u_viol", 1, 2'b10, 0, 16'h0); step;
      drive(0, SRst, 16'h0000, 0, 0, 16'h0000); want_all("u_rearm", 0, 2'b00, 0, 16'h0); step;

      // Overflow vs. circular drop on the DEPTH=4 instances
      for (int i = 1; i <= 4; i++) begin
         drive(0, SIn, 16'h0300, 1, 0, 16'hA000 + 16'(i));
         want_all("o_fill", 0, 0, 4'(i), 16'hA000 + 16'(i));
         step;
      end
      drive(0, SIn, 16'h0300, 1, 0, 16'hA005);
      want(0, "o_push5", 0, 2'b00, 5, 16'hA005);
      want(1, "o_push5", 1, 2'b11, 0, 16'h0000);
      want(2, "o_push5", 0, 2'b00, 4, 16'hA005);
      step;
      for (int i = 5; i >= 2; i--) begin
         drive(0, SIn, 16'hA000 + 16'(i), 0, 1, 16'h0000);
         want(0, "o_exit", 0, 0, 4'(i - 1), 16'hA000 + 16'(i - 1));
         want(1, "o_exit", 1, 2'b11, 0, 16'h0000);
         want(2, "o_exit", 0, 0, 4'(i - 2), (i == 2) ? 16'h0000 : 16'hA000 + 16'(i - 1));
         step;
      end
      drive(0, SIn, 16'hA001, 0, 1, 16'h0000);
      want(0, "o_exit1", 0, 2'b00, 0, 16'h0000);
      want(1, "o_exit1", 1, 2'b11, 0, 16'h0000);
      want(2, "o_exit1", 1, 2'b10, 0, 16'h0000);
      step;
      drive(0, SRst, 16'h0000, 0, 0, 16'h0000); want_all("o_rearm", 0, 2'b00, 0, 16'h0); step;

      // IRQ freeze
      drive(0, SIn, 16'h0400, 1, 0, 16'h4000);  want_all("i_push", 0, 0, 1, 16'h4000);   step;
      drive(0, SIrq, 16'h9999, 1, 1, 16'h7777); want_all("i_frz1", 0, 0, 1, 16'h4000);   step;
      drive(0, SIrq, 16'h9999, 0, 1, 16'h0000); want_all("i_frz2", 0, 0, 1, 16'h4000);   step;
      drive(0, SIn, 16'h4000, 0, 1, 16'h0000);  want_all("i_pop", 0, 0, 0, 16'h0000);    step;

      // Same-cycle exit+enter replaces the top
      drive(0, SIn, 16'h0500, 1, 0, 16'h4800); want_all("r_push1", 0, 0, 1, 16'h4800); step;
      drive(0, SIn, 16'h0504, 1, 0, 16'h5000); want_all("r_push2", 0, 0, 2, 16'h5000); step;
      drive(0, SIn, 16'h5000, 1, 1, 16'h6000); want_all("r_repl", 0, 0, 2, 16'h6000);  step;
      drive(0, SIn, 16'h6000, 0, 1, 16'h0000); want_all("r_pop", 0, 0, 1, 16'h4800);   step;
      drive(0, SRst, 16'h0010, 0, 0, 16'h0000); want_all("r_badrst", 1, 2'b00, 0, 16'h0); step;
      drive(0, SRst, 16'h0000, 0, 0, 16'h0000); want_all("r_rearm", 0, 2'b00, 0, 16'h0); step;

      // Mismatch outranks overflow when full
      for (int i = 1; i <= 4; i++) begin
         drive(0, SIn, 16'h0600, 1, 0, 16'hB000 + 16'(i));
         want_all("p_fill", 0, 0, 4'(i), 16'hB000 + 16'(i));
         step;
      end
      drive(0, SIn, 16'hBEEF, 1, 1, 16'hB005); want_all("p_prio", 1, 2'b01, 0, 16'h0); step;
      drive(0, SRst, 16'h0000, 0, 0, 16'h0000); want_all("p_rearm", 0, 2'b00, 0, 16'h0); step;

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
